// File: rtl/io_port_hub.sv
// io_port_hub: CPU-side select/write queue feeding NUM_DEV peripherals through a
// shared tagged FIFO, drained in order with per-device valid/ready and a timeout.
module io_port_hub #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEV_W   = 2,
    parameter int unsigned FIFO_AW = 3,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    inout  wire  [DATA_W-1:0]             main_bus,
    input  logic                          sel_load_n,
    input  logic                          wr_n,
    input  logic                          rd_n,
    input  logic                          out_rst,
    output logic [(2**DEV_W)-1:0]         dev_valid,
    input  logic [(2**DEV_W)-1:0]         dev_ready,
    output logic [DATA_W-1:0]             dev_data,
    output logic                          dev_rs,
    input  logic [(2**DEV_W)*DATA_W-1:0]  dev_rdata,
    output logic [FIFO_AW:0]              fifo_level,
    output logic                          err
);

    localparam int unsigned NUM_DEV = 2**DEV_W;
    localparam int unsigned DEPTH   = 2**FIFO_AW;
    localparam int unsigned TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [DEV_W-1:0]  dev;
        logic              rs;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    logic [DEV_W-1:0]   sel_dev;
    logic               sel_rs;
    entry_t             mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               ovf_q;
    logic               tmo_q;
    state_t             state;
    state_t             state_nxt;
    logic [TMR_W-1:0]   timer;
    logic [DEV_W-1:0]   out_tag;

    entry_t             head_c;
    logic               full_c;
    logic               empty_c;
    logic               push_req_c;
    logic               push_c;
    logic               ovf_evt_c;
    logic               pop_c;
    logic               tmo_evt_c;
    logic               done_c;
    logic               clr_c;
    logic               ovf_nxt_c;
    logic               tmo_nxt_c;
    logic [DATA_W-1:0]  status_c;
    logic [DATA_W-1:0]  rdata_c;
    logic [DATA_W-1:0]  rd_data_c;

    // Full is judged on the pre-edge level, so a same-cycle pop never rescues a push
    assign full_c     = (fifo_level == (FIFO_AW+1)'(DEPTH));
    assign empty_c    = (fifo_level == '0);
    assign push_req_c = !wr_n && rd_n;
    assign push_c     = push_req_c && !full_c && !out_rst;
    assign ovf_evt_c  = push_req_c && full_c && !out_rst;
    assign head_c     = mem[rd_ptr];
    assign clr_c      = !rd_n && sel_rs;
    assign ovf_nxt_c  = ovf_evt_c | (ovf_q & ~clr_c);
    assign tmo_nxt_c  = tmo_evt_c | (tmo_q & ~clr_c);

    // Select register: device index and register-select bit for later writes/reads
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_dev <= '0;
            sel_rs  <= 1'b0;
        end else if (!sel_load_n) begin
            sel_dev <= main_bus[DEV_W-1:0];
            sel_rs  <= main_bus[DEV_W];
        end
    end

    // FIFO storage; the tag uses the select value held before this edge
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= '{dev: sel_dev, rs: sel_rs, data: main_bus};
        end
    end

    // FIFO pointers and explicit occupancy count
    always_ff @(posedge clk) begin
        if (reset || out_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_c, pop_c})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow/timeout flags; a same-cycle event beats a status-read clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
            err   <= 1'b0;
        end else begin
            ovf_q <= ovf_nxt_c;
            tmo_q <= tmo_nxt_c;
            err   <= ovf_nxt_c | tmo_nxt_c;
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Drain FSM next-state: pop on idle, complete on ready or timeout, chain without bubble
    always_comb begin
        state_nxt = state;
        pop_c     = 1'b0;
        tmo_evt_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty_c) begin
                    pop_c     = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (dev_ready[out_tag]) begin
                    done_c = 1'b1;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    done_c    = 1'b1;
                    tmo_evt_c = 1'b1;
                end
                if (done_c) begin
                    if (!empty_c) pop_c     = 1'b1;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (out_rst) begin
            state_nxt = IDLE;
            pop_c     = 1'b0;
            tmo_evt_c = 1'b0;
        end
    end

    // Output register and presentation timer
    always_ff @(posedge clk) begin
        if (reset) begin
            dev_valid <= '0;
            dev_data  <= '0;
            dev_rs    <= 1'b0;
            out_tag   <= '0;
            timer     <= '0;
        end else if (out_rst) begin
            dev_valid <= '0;
            timer     <= '0;
        end else if (pop_c) begin
            dev_valid <= NUM_DEV'(1) << head_c.dev;
            dev_data  <= head_c.data;
            dev_rs    <= head_c.rs;
            out_tag   <= head_c.dev;
            timer     <= '0;
        end else if (state == PRESENT && state_nxt == IDLE) begin
            dev_valid <= '0;
            timer     <= '0;
        end else if (state == PRESENT) begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Read-back mux: selected device data or zero-extended hub status
    always_comb begin
        rdata_c  = '0;
        status_c = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_dev == DEV_W'(i)) rdata_c = dev_rdata[i*DATA_W +: DATA_W];
        end
        status_c[0]               = full_c;
        status_c[1]               = empty_c;
        status_c[2]               = ovf_q;
        status_c[3]               = tmo_q;
        status_c[4 +: FIFO_AW+1]  = fifo_level;
        rd_data_c = sel_rs ? status_c : rdata_c;
    end

    assign main_bus = rd_n ? {DATA_W{1'bz}} : rd_data_c;

endmodule

// File: tb/tb_io_port_hub.sv
// Scoreboard bench for io_port_hub: expected transfers queued at stimulus time,
// compared by a monitor whenever a device handshake is presented.
module tb_io_port_hub;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEV_W   = 2;
    localparam int unsigned FIFO_AW = 3;
    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        sel_load_n;
    logic        wr_n;
    logic        rd_n;
    logic        out_rst;
    logic [3:0]  dev_valid;
    logic [3:0]  dev_ready;
    logic [7:0]  dev_data;
    logic        dev_rs;
    logic [31:0] dev_rdata;
    logic [3:0]  fifo_level;
    logic        err;
    wire  [7:0]  main_bus;
    logic        tb_drv;
    logic [7:0]  tb_bus;

    int          checks;
    int          errors;
    bit          done;
    logic [10:0] exp_q [$];

    assign main_bus = tb_drv ? tb_bus : 8'bz;

    io_port_hub #(
        .DATA_W  (DATA_W),
        .DEV_W   (DEV_W),
        .FIFO_AW (FIFO_AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .main_bus   (main_bus),
        .sel_load_n (sel_load_n),
        .wr_n       (wr_n),
        .rd_n       (rd_n),
        .out_rst    (out_rst),
        .dev_valid  (dev_valid),
        .dev_ready  (dev_ready),
        .dev_data   (dev_data),
        .dev_rs     (dev_rs),
        .dev_rdata  (dev_rdata),
        .fifo_level (fifo_level),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_load(input logic [7:0] v);
        tb_drv = 1'b1; tb_bus = v; sel_load_n = 1'b0;
        tick();
        sel_load_n = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] v);
        tb_drv = 1'b1; tb_bus = v; wr_n = 1'b0;
        tick();
        wr_n = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic status_peek(input string name, input logic [7:0] exp);
        rd_n = 1'b0;
        #1;
        chk(name, main_bus, exp);
    endtask

    initial begin
        logic [10:0] e;
        checks = 0; errors = 0; done = 1'b0;
        reset = 1'b1; sel_load_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; out_rst = 1'b0;
        dev_ready = 4'b0000; dev_rdata = {8'h7E, 8'h33, 8'h22, 8'h11};
        tb_drv = 1'b0; tb_bus = 8'h00;
        fork
            // Monitor: every accepted presentation must match the next expected entry
            begin
                while (!done) begin
                    @(negedge clk);
                    if (!reset && dev_valid != 4'b0000) begin
                        chk("valid_onehot", $countones(dev_valid), 1);
                        for (int i = 0; i < 4; i++) begin
                            if (dev_valid[i] && dev_ready[i]) begin
                                if (exp_q.size() == 0) begin
                                    checks++; errors++;
                                    $display("FAIL unexpected_xfer: got dev %0d data 0x%0h expected none", i, dev_data);
                                end else begin
                                    e = exp_q.pop_front();
                                    chk("xfer_tag_rs_data", {2'(i), dev_rs, dev_data}, e);
                                end
                            end
                        end
                    end
                end
            end
            // Stimulus
            begin
                tick(); tick(); tick();
                reset = 1'b0;
                chk("rst_dev_valid", dev_valid, 0);
                chk("rst_dev_data", dev_data, 0);
                chk("rst_dev_rs", dev_rs, 0);
                chk("rst_fifo_level", fifo_level, 0);
                chk("rst_err", err, 0);
                tb_drv = 1'b1; tb_bus = 8'hA5; #1;
                chk("rst_bus_released", main_bus, 8'hA5);
                tb_drv = 1'b0;

                // Single write to dev1/rs1 with ready held
                dev_ready = 4'b0010;
                sel_load(8'h05);
                exp_q.push_back({2'd1, 1'b1, 8'h41});
                bus_write(8'h41);
                chk("t1_valid_at_push", dev_valid, 4'b0000);
                chk("t1_level_at_push", fifo_level, 1);
                tick();
                chk("t1_valid", dev_valid, 4'b0010);
                chk("t1_rs", dev_rs, 1);
                chk("t1_data", dev_data, 8'h41);
                tick();
                chk("t1_valid_idle", dev_valid, 4'b0000);
                chk("t1_level_idle", fifo_level, 0);

                // Overflow: 12 writes with dev2 stalled, other readies high and ignored
                dev_ready = 4'b1011;
                sel_load(8'h02);
                for (int k = 1; k <= 12; k++) bus_write(8'(8'h10 + k));
                chk("t2_level_full", fifo_level, 8);
                chk("t2_err", err, 1);
                sel_load(8'h04);
                status_peek("t2_status1", 8'h8D);
                tick();
                chk("t2_status2", main_bus, 8'h78);
                rd_n = 1'b1;
                out_rst = 1'b1; tick(); out_rst = 1'b0;
                chk("t2_flush_valid", dev_valid, 0);
                chk("t2_flush_level", fifo_level, 0);

                // Clear stickies, then timeout on dev0
                rd_n = 1'b0; tick(); rd_n = 1'b1;
                chk("t3_err_cleared", err, 0);
                dev_ready = 4'b1110;
                sel_load(8'h00);
                bus_write(8'hA1);
                bus_write(8'hB2);
                chk("t3_hold0_valid", dev_valid, 4'b0001);
                chk("t3_hold0_data", dev_data, 8'hA1);
                for (int k = 1; k <= 3; k++) begin
                    tick();
                    chk("t3_hold_valid", dev_valid, 4'b0001);
                    chk("t3_hold_data", dev_data, 8'hA1);
                end
                tick();
                chk("t3_next_valid", dev_valid, 4'b0001);
                chk("t3_next_data", dev_data, 8'hB2);
                chk("t3_err", err, 1);
                sel_load(8'h04);
                status_peek("t3_status", 8'h0A);
                rd_n = 1'b1;
                out_rst = 1'b1; tick(); out_rst = 1'b0;
                chk("t3_flush_valid", dev_valid, 0);

                // Back-to-back to dev2 with ready held
                sel_load(8'h02);
                dev_ready = 4'b0100;
                exp_q.push_back({2'd2, 1'b0, 8'hC1});
                exp_q.push_back({2'd2, 1'b0, 8'hC2});
                exp_q.push_back({2'd2, 1'b0, 8'hC3});
                bus_write(8'hC1);
                bus_write(8'hC2);
                chk("t4_v1", dev_valid, 4'b0100);
                chk("t4_d1", dev_data, 8'hC1);
                bus_write(8'hC3);
                chk("t4_v2", dev_valid, 4'b0100);
                chk("t4_d2", dev_data, 8'hC2);
                tick();
                chk("t4_v3", dev_valid, 4'b0100);
                chk("t4_d3", dev_data, 8'hC3);
                tick();
                chk("t4_idle", dev_valid, 4'b0000);

                // Device read-back from dev3; a write during read is ignored
                dev_ready = 4'b0000;
                sel_load(8'h03);
                status_peek("t5_rdata", 8'h7E);
                wr_n = 1'b0; tick(); wr_n = 1'b1;
                chk("t5_wr_during_rd_level", fifo_level, 0);
                rd_n = 1'b1;
                tb_drv = 1'b1; tb_bus = 8'h5C; #1;
                chk("t5_bus_released", main_bus, 8'h5C);
                tb_drv = 1'b0;
                tick();
                chk("t5_no_present", dev_valid, 4'b0000);

                // out_rst mid-PRESENT with a colliding write
                sel_load(8'h01);
                for (int k = 1; k <= 4; k++) bus_write(8'(8'h60 + k));
                chk("t6_level", fifo_level, 3);
                chk("t6_valid", dev_valid, 4'b0010);
                tb_drv = 1'b1; tb_bus = 8'h99; wr_n = 1'b0; out_rst = 1'b1;
                tick();
                out_rst = 1'b0; wr_n = 1'b1; tb_drv = 1'b0;
                chk("t6_flush_valid", dev_valid, 0);
                chk("t6_flush_level", fifo_level, 0);
                chk("t6_err_kept", err, 1);
                sel_load(8'h04);
                status_peek("t6_status", 8'h0A);
                rd_n = 1'b1;

                // Simultaneous select load and write: entry keeps old select (dev0/rs1)
                dev_ready = 4'b0001;
                exp_q.push_back({2'd0, 1'b1, 8'h5A});
                tb_drv = 1'b1; tb_bus = 8'h5A; sel_load_n = 1'b0; wr_n = 1'b0;
                tick();
                sel_load_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0;
                tick();
                chk("t7_valid", dev_valid, 4'b0001);
                chk("t7_rs", dev_rs, 1);
                chk("t7_data", dev_data, 8'h5A);
                for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
                chk("drain_empty", exp_q.size(), 0);
                status_peek("t7_new_sel_rdata", 8'h33);
                rd_n = 1'b1;
                tick();
                done = 1'b1;
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
